output_port_arbiter: RTL and testbench

//  Responder side of the buffer_unit port-request interface: one instance per router output port.

---
 rtl/output_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_output_port_arbiter.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// ============================================================================
// Module      : output_port_arbiter
// Description : Round-robin owner arbiter for one router output port; muxes the
//               owner's 4-phase flit link onto the output link.
//               Optional idle-link forced release under macro ARB_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module output_port_arbiter #(
  parameter int N_IN    = 5,
  parameter int DW      = 18,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN-1:0]    req_port,
  output logic [N_IN-1:0]    grant_port,
  input  logic [N_IN*DW-1:0] data_in,
  input  logic [N_IN-1:0]    req_in,
  output logic [N_IN-1:0]    ack_out,
  output logic [DW-1:0]      data_out,
  output logic               req_out,
  input  logic               ack_in,
  output logic               timeout_err
);

  localparam int OW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [OW-1:0]   owner_q,  owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_IN-1:0] grant_q,  grant_d;

  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [OW:0]     cand;
  logic            link_idle;
  logic            owner_done;
  logic            force_rel;
  logic [OW-1:0]   next_ptr;

  // First requester at or after rr_ptr, wrapping modulo N_IN.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand = {1'b0, rr_ptr_q} + (OW+1)'(i);
      if (cand >= (OW+1)'(N_IN)) begin
        cand = cand - (OW+1)'(N_IN);
      end
      if (!pick_vld && req_port[cand[OW-1:0]]) begin
        pick     = cand[OW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign link_idle  = !req_in[owner_q] && !ack_in;
  assign owner_done = !req_port[owner_q] && link_idle;
  assign next_ptr   = (owner_q == OW'(N_IN-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        // Ownership is only surrendered with the link quiescent, so no flit is cut.
        if (owner_done || force_rel) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  always_comb begin
    idle_cnt_d    = '0;
    force_rel     = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q == S_GRANT && link_idle) begin
      if (idle_cnt_q == CW'(TIMEOUT-1)) begin
        force_rel     = 1'b1;
        timeout_err_d = !owner_done;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;

  assign force_rel      = 1'b0;
  assign timeout_err    = 1'b0;
  // TIMEOUT only matters when the idle counter is built.
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign grant_port = grant_q;

  // grant_q is one-hot only while a grant is held, so the AND-OR mux is zero otherwise.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_q[i]) begin
        data_out = data_out | data_in[i*DW +: DW];
      end
    end
  end

  assign req_out = |(grant_q & req_in);

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_ack
      assign ack_out[gi] = grant_q[gi] & ack_in;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: expected grants and flits are queued
// when stimulus is driven and popped when the DUT presents them.
`timescale 1ns/1ps
`default_nettype none

module tb_output_port_arbiter;

  localparam int N_IN = 5;
  localparam int DW   = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_IN-1:0]    req_port;
  logic [N_IN-1:0]    grant_port;
  logic [N_IN*DW-1:0] data_in;
  logic [N_IN-1:0]    req_in;
  logic [N_IN-1:0]    ack_out;
  logic [DW-1:0]      data_out;
  logic               req_out;
  logic               ack_in;
  logic               timeout_err;

  int checks   = 0;
  int failures = 0;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;

  int          exp_grant_q[$];
  logic [DW-1:0] exp_flit_q[$];

  output_port_arbiter #(
    .N_IN    (N_IN),
    .DW      (DW),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_port    (req_port),
    .grant_port  (grant_port),
    .data_in     (data_in),
    .req_in      (req_in),
    .ack_out     (ack_out),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Downstream receiver: acks follow req one cycle later, or a manual level.
  initial begin
    ack_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      ack_in = auto_ack ? req_out : man_ack;
    end
  end

  function automatic logic [N_IN-1:0] oh(input int u);
    logic [N_IN-1:0] v;
    v    = '0;
    v[u] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_data();
    for (int i = 0; i < N_IN; i++) data_in[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic wait_grant(output bit ok, output int cyc);
    cyc = 0;
    while ((|grant_port) !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = ((|grant_port) === 1'b1);
  endtask

  task automatic wait_nogrant(output bit ok);
    int n;
    n = 0;
    while (grant_port !== '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (grant_port === '0);
  endtask

  // One full 4-phase flit from unit u; returns what the link showed.
  task automatic drive_flit(input int u, input logic [DW-1:0] d,
                            output logic [DW-1:0] seen, output logic [N_IN-1:0] acks,
                            output bit ok);
    int n;
    tick();
    data_in[u*DW +: DW] = d;
    req_in[u]           = 1'b1;
    exp_flit_q.push_back(d);
    @(negedge clk);
    seen = data_out;
    n = 0;
    while (ack_out[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    acks = ack_out;
    ok   = (ack_out[u] === 1'b1);
    tick();
    req_in[u] = 1'b0;
    n = 0;
    while (ack_out[u] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = ok && (ack_out[u] === 1'b0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0; req_port = '0; req_in = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_port = '1; req_in = '1; man_ack = 1'b1; auto_ack = 1'b0;
    junk_data();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (grant_port !== '0 || timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_grant: grant=%b terr=%b, want 00000/0", grant_port, timeout_err);
      end
      checks++;
      if (req_out !== 1'b0 || ack_out !== '0 || data_out !== '0) begin
        failures++;
        $display("FAIL reset_link: req=%b ack=%b data=%h, want 0", req_out, ack_out, data_out);
      end
    end
    tick();
    rst = 1'b1; req_port = '0; req_in = '0; man_ack = 1'b0; auto_ack = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] flits [3];
    logic [DW-1:0] seen, e;
    logic [N_IN-1:0] acks;
    bit ok;
    int cyc, eg;
    flits[0] = 18'h003A5; flits[1] = 18'h2C4B7; flits[2] = 18'h3FFFF;
    junk_data();
    req_in[0] = 1'b1;
    exp_grant_q.push_back(2);
    tick();
    req_port[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_port !== '0) begin
      failures++;
      $display("FAIL single_early: grant=%b, want 00000", grant_port);
    end
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || cyc != 1 || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL single_grant: grant=%b after %0d clk, want %b after 1", grant_port, cyc, oh(eg));
    end
    checks++;
    if (req_out !== 1'b0) begin
      failures++;
      $display("FAIL single_noise: req_out=%b, want 0", req_out);
    end
    for (int f = 0; f < 3; f++) begin
      drive_flit(2, flits[f], seen, acks, ok);
      e = exp_flit_q.pop_front();
      checks++;
      if (!ok || seen !== e) begin
        failures++;
        $display("FAIL single_flit%0d: data=%h ok=%0d, want %h", f, seen, ok, e);
      end
      checks++;
      if (acks !== oh(2)) begin
        failures++;
        $display("FAIL single_ack%0d: ack_out=%b, want %b", f, acks, oh(2));
      end
    end
    tick();
    req_port[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_port !== oh(2)) begin
      failures++;
      $display("FAIL single_hold: grant=%b, want %b", grant_port, oh(2));
    end
    @(negedge clk);
    checks++;
    if (grant_port !== '0) begin
      failures++;
      $display("FAIL single_release: grant=%b, want 00000", grant_port);
    end
    req_in[0] = 1'b0;
  endtask

  task automatic test_all_request();
    int order [6];
    logic [DW-1:0] seen, e;
    logic [N_IN-1:0] acks;
    bit ok;
    int cyc, eg, u;
    order = '{0, 1, 2, 3, 4, 0};
    do_reset();
    foreach (order[k]) exp_grant_q.push_back(order[k]);
    tick();
    req_port = '1;
    for (int k = 0; k < 6; k++) begin
      u = order[k];
      wait_grant(ok, cyc);
      eg = exp_grant_q.pop_front();
      checks++;
      if (!ok || grant_port !== oh(eg)) begin
        failures++;
        $display("FAIL rr_order%0d: grant=%b, want %b", k, grant_port, oh(eg));
      end
      drive_flit(u, DW'(18'h10000 + k), seen, acks, ok);
      e = exp_flit_q.pop_front();
      checks++;
      if (!ok || seen !== e || acks !== oh(u)) begin
        failures++;
        $display("FAIL rr_flit%0d: data=%h ack=%b, want %h/%b", k, seen, acks, e, oh(u));
      end
      tick();
      req_port[u] = 1'b0;
      wait_nogrant(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_release%0d: grant=%b, want 00000", k, grant_port);
      end
      if (k == 0) begin
        tick();
        req_port[0] = 1'b1;
      end
    end
  endtask

  task automatic test_hold_mid_handshake();
    logic [DW-1:0] e;
    bit ok;
    int cyc, eg;
    exp_grant_q.push_back(1);
    tick();
    req_port[1] = 1'b1;
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL hold_grant: grant=%b, want %b", grant_port, oh(eg));
    end
    auto_ack = 1'b0; man_ack = 1'b0;
    tick();
    data_in[1*DW +: DW] = 18'h2A5A5;
    req_in[1] = 1'b1;
    exp_flit_q.push_back(18'h2A5A5);
    @(negedge clk);
    e = exp_flit_q.pop_front();
    checks++;
    if (data_out !== e || req_out !== 1'b1) begin
      failures++;
      $display("FAIL hold_flit: data=%h req=%b, want %h/1", data_out, req_out, e);
    end
    tick();
    req_port[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (grant_port !== oh(1)) begin
        failures++;
        $display("FAIL hold_busy: grant=%b, want %b", grant_port, oh(1));
      end
    end
    tick();
    man_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_out !== oh(1)) begin
      failures++;
      $display("FAIL hold_ack_route: ack_out=%b, want %b", ack_out, oh(1));
    end
    tick();
    req_in[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_port !== oh(1) || req_out !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack_high: grant=%b req=%b, want %b/0", grant_port, req_out, oh(1));
    end
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_port !== oh(1)) begin
      failures++;
      $display("FAIL hold_last: grant=%b, want %b", grant_port, oh(1));
    end
    @(negedge clk);
    checks++;
    if (grant_port !== '0) begin
      failures++;
      $display("FAIL hold_clear: grant=%b, want 00000", grant_port);
    end
    auto_ack = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    logic [DW-1:0] seen, e;
    logic [N_IN-1:0] acks;
    bit ok;
    int cyc, eg;
    exp_grant_q.push_back(3);
    tick();
    req_port[3] = 1'b1;
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL rmid_grant: grant=%b, want %b", grant_port, oh(eg));
    end
    drive_flit(3, 18'h15555, seen, acks, ok);
    e = exp_flit_q.pop_front();
    checks++;
    if (!ok || seen !== e) begin
      failures++;
      $display("FAIL rmid_flit1: data=%h, want %h", seen, e);
    end
    auto_ack = 1'b0;
    tick();
    data_in[3*DW +: DW] = 18'h0AAAA;
    req_in[3] = 1'b1;
    exp_flit_q.push_back(18'h0AAAA);
    @(negedge clk);
    e = exp_flit_q.pop_front();
    checks++;
    if (data_out !== e || req_out !== 1'b1) begin
      failures++;
      $display("FAIL rmid_flit2: data=%h req=%b, want %h/1", data_out, req_out, e);
    end
    tick();
    rst = 1'b0; req_port = '0; req_in = '0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_port !== '0 || req_out !== 1'b0 || ack_out !== '0 || data_out !== '0) begin
      failures++;
      $display("FAIL rmid_outputs: grant=%b req=%b ack=%b data=%h, want 0", grant_port, req_out, ack_out, data_out);
    end
    auto_ack = 1'b1;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(3);
    tick();
    req_port = 5'b01001;
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL rmid_rrptr: grant=%b, want %b", grant_port, oh(eg));
    end
    tick();
    req_port[0] = 1'b0;
    wait_nogrant(ok);
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL rmid_next: grant=%b, want %b", grant_port, oh(eg));
    end
    tick();
    req_port[3] = 1'b0;
    wait_nogrant(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rmid_release: grant=%b, want 00000", grant_port);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc, eg;
`ifdef ARB_TIMEOUT_EN
    int  held;
    bit  early;
    exp_grant_q.push_back(4);
    exp_grant_q.push_back(4);
    tick();
    req_port[4] = 1'b1;
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL tmo_grant: grant=%b, want %b", grant_port, oh(eg));
    end
    held  = 1;
    early = (timeout_err !== 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_port !== oh(4)) break;
      held++;
      if (timeout_err !== 1'b0) early = 1'b1;
    end
    checks++;
    if (held != 8 || early) begin
      failures++;
      $display("FAIL tmo_cycles: held=%0d early_err=%0d, want 8/0", held, early);
    end
    checks++;
    if (timeout_err !== 1'b1 || grant_port !== '0) begin
      failures++;
      $display("FAIL tmo_pulse: terr=%b grant=%b, want 1/00000", timeout_err, grant_port);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_single: terr=%b, want 0", timeout_err);
    end
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL tmo_regrant: grant=%b, want %b", grant_port, oh(eg));
    end
`else
    bit bad;
    exp_grant_q.push_back(4);
    tick();
    req_port[4] = 1'b1;
    wait_grant(ok, cyc);
    eg = exp_grant_q.pop_front();
    checks++;
    if (!ok || grant_port !== oh(eg)) begin
      failures++;
      $display("FAIL persist_grant: grant=%b, want %b", grant_port, oh(eg));
    end
    bad = 1'b0;
    repeat (110) begin
      @(negedge clk);
      if (grant_port !== oh(4) || timeout_err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL persist_hold: grant=%b terr=%b, want %b/0 for 110 clk", grant_port, timeout_err, oh(4));
    end
`endif
    tick();
    req_port[4] = 1'b0;
    wait_nogrant(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_release: grant=%b, want 00000", grant_port);
    end
  endtask

  initial begin
    req_port = '0;
    req_in   = '0;
    data_in  = '0;
    test_reset();
    test_single();
    test_all_request();
    test_hold_mid_handshake();
    test_reset_mid_packet();
    test_timeout();
    checks++;
    if (exp_grant_q.size() != 0 || exp_flit_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: grants=%0d flits=%0d left, want 0/0",
               exp_grant_q.size(), exp_flit_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
